// File: rtl/ws_pe_pkg.sv
// Shared types and constants for the weight-stationary processing element
// and the array-level logic that reuses its saturating adder.
package ws_pe_pkg;

  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_WEIGHT_WIDTH = 16;
  localparam int DEF_ACC_WIDTH    = 40;
  localparam bit DEF_SATURATE     = 1'b1;
  localparam int MAX_ACC_WIDTH    = 128;

  typedef enum logic {
    PE_MAC    = 1'b0,
    PE_BYPASS = 1'b1
  } pe_mode_e;

  // Largest positive value of an acc_w-bit signed number, held in a wide word
  // so callers of any accumulator width can slice the low bits.
  function automatic logic signed [MAX_ACC_WIDTH-1:0] sat_max(input int unsigned acc_w);
    logic signed [MAX_ACC_WIDTH-1:0] one;
    one = 1;
    return (one <<< (acc_w - 1)) - one;
  endfunction

  function automatic logic signed [MAX_ACC_WIDTH-1:0] sat_min(input int unsigned acc_w);
    return ~sat_max(acc_w);
  endfunction

endpackage

// File: rtl/ws_pe_sat_add.sv
// Combinational signed add with one guard bit; clamps or wraps on overflow
// and flags it. Also used by the array's output drain.
module sat_add import ws_pe_pkg::*; #(
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter bit SATURATE  = DEF_SATURATE
) (
  input  logic signed [ACC_WIDTH-1:0] a_i,
  input  logic signed [ACC_WIDTH-1:0] b_i,
  output logic signed [ACC_WIDTH-1:0] sum_o,
  output logic                        ovf_o
);

  localparam logic signed [MAX_ACC_WIDTH-1:0] MAX_FULL = sat_max(ACC_WIDTH);
  localparam logic signed [MAX_ACC_WIDTH-1:0] MIN_FULL = sat_min(ACC_WIDTH);
  localparam logic signed [ACC_WIDTH-1:0]     ACC_MAX  = MAX_FULL[ACC_WIDTH-1:0];
  localparam logic signed [ACC_WIDTH-1:0]     ACC_MIN  = MIN_FULL[ACC_WIDTH-1:0];

  logic signed [ACC_WIDTH:0] sum_ext;

  // Overflow shows as the guard bit disagreeing with the result sign bit.
  function automatic logic signed [ACC_WIDTH-1:0] clamp(input logic signed [ACC_WIDTH:0] s);
    if ((s[ACC_WIDTH] != s[ACC_WIDTH-1]) && SATURATE)
      return s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    return s[ACC_WIDTH-1:0];
  endfunction

  assign sum_ext = {a_i[ACC_WIDTH-1], a_i} + {b_i[ACC_WIDTH-1], b_i};
  assign sum_o   = clamp(sum_ext);
  assign ovf_o   = sum_ext[ACC_WIDTH] ^ sum_ext[ACC_WIDTH-1];

endmodule

// File: rtl/ws_pe.sv
// Weight-stationary PE: double-buffered weight, two-stage multiply/accumulate
// toward the south, one-cycle activation forwarding to the east.
module ws_pe import ws_pe_pkg::*; #(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  parameter int ACC_WIDTH    = DEF_ACC_WIDTH,
  parameter bit SATURATE     = DEF_SATURATE
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           stall_i,
  input  logic                           mode_i,
  input  logic                           w_load_i,
  input  logic signed [WEIGHT_WIDTH-1:0] weight_i,
  input  logic                           w_swap_i,
  output logic                           w_load_o,
  output logic signed [WEIGHT_WIDTH-1:0] weight_o,
  input  logic                           data_valid_i,
  input  logic signed [DATA_WIDTH-1:0]   data_i,
  output logic                           data_valid_o,
  output logic signed [DATA_WIDTH-1:0]   data_o,
  input  logic                           psum_valid_i,
  input  logic signed [ACC_WIDTH-1:0]    psum_i,
  output logic                           psum_valid_o,
  output logic signed [ACC_WIDTH-1:0]    psum_o,
  input  logic                           ovf_clr_i,
  output logic                           ovf_o
);

  localparam int PROD_W = DATA_WIDTH + WEIGHT_WIDTH;

  pe_mode_e mode;

  logic signed [WEIGHT_WIDTH-1:0] w_shd_q, w_shd_d;
  logic signed [WEIGHT_WIDTH-1:0] w_act_q, w_act_d;
  logic signed [WEIGHT_WIDTH-1:0] weight_q, weight_d;
  logic                           w_load_q, w_load_d;

  logic signed [PROD_W-1:0]       prod_p1_q, prod_p1_d;
  logic signed [ACC_WIDTH-1:0]    addend_p1_q, addend_p1_d;
  logic                           vld_p1_q, vld_p1_d;
  logic signed [DATA_WIDTH-1:0]   data_p1_q, data_p1_d;
  logic                           dvld_p1_q, dvld_p1_d;

  logic signed [ACC_WIDTH-1:0]    psum_p2_q, psum_p2_d;
  logic                           vld_p2_q, vld_p2_d;
  logic                           ovf_q, ovf_d;

  logic signed [PROD_W-1:0]       mult;
  logic signed [ACC_WIDTH-1:0]    prod_ext;
  logic signed [ACC_WIDTH-1:0]    sum;
  logic                           sum_ovf;

  assign mode     = pe_mode_e'(mode_i);
  assign mult     = PROD_W'(data_i) * PROD_W'(w_act_q);
  assign prod_ext = ACC_WIDTH'(prod_p1_q);

  sat_add #(
    .ACC_WIDTH (ACC_WIDTH),
    .SATURATE  (SATURATE)
  ) u_sat_add (
    .a_i   (addend_p1_q),
    .b_i   (prod_ext),
    .sum_o (sum),
    .ovf_o (sum_ovf)
  );

  always_comb begin
    w_shd_d     = w_shd_q;
    w_act_d     = w_act_q;
    weight_d    = weight_i;
    w_load_d    = w_load_i;
    prod_p1_d   = prod_p1_q;
    addend_p1_d = addend_p1_q;
    vld_p1_d    = vld_p1_q;
    data_p1_d   = data_p1_q;
    dvld_p1_d   = dvld_p1_q;
    psum_p2_d   = psum_p2_q;
    vld_p2_d    = vld_p2_q;
    ovf_d       = ovf_q & ~ovf_clr_i;

    // Weight buffers run free of stall; a same-cycle swap sees the old shadow.
    if (w_load_i) w_shd_d = weight_i;
    if (w_swap_i) w_act_d = w_shd_q;

    // Stage p1: operand capture and multiply against the active weight
    if (!stall_i) begin
      prod_p1_d   = (data_valid_i && mode == PE_MAC) ? mult : '0;
      addend_p1_d = psum_valid_i ? psum_i : '0;
      vld_p1_d    = data_valid_i | psum_valid_i;
      data_p1_d   = data_i;
      dvld_p1_d   = data_valid_i;
    end

    // Stage p2: accumulate into the southbound partial sum
    if (!stall_i) begin
      psum_p2_d = sum;
      vld_p2_d  = vld_p1_q;
      if (vld_p1_q && sum_ovf) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_shd_q     <= '0;
      w_act_q     <= '0;
      weight_q    <= '0;
      w_load_q    <= 1'b0;
      prod_p1_q   <= '0;
      addend_p1_q <= '0;
      vld_p1_q    <= 1'b0;
      data_p1_q   <= '0;
      dvld_p1_q   <= 1'b0;
      psum_p2_q   <= '0;
      vld_p2_q    <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      w_shd_q     <= w_shd_d;
      w_act_q     <= w_act_d;
      weight_q    <= weight_d;
      w_load_q    <= w_load_d;
      prod_p1_q   <= prod_p1_d;
      addend_p1_q <= addend_p1_d;
      vld_p1_q    <= vld_p1_d;
      data_p1_q   <= data_p1_d;
      dvld_p1_q   <= dvld_p1_d;
      psum_p2_q   <= psum_p2_d;
      vld_p2_q    <= vld_p2_d;
      ovf_q       <= ovf_d;
    end
  end

  assign w_load_o     = w_load_q;
  assign weight_o     = weight_q;
  assign data_valid_o = dvld_p1_q;
  assign data_o       = data_p1_q;
  assign psum_valid_o = vld_p2_q;
  assign psum_o       = psum_p2_q;
  assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_ws_pe.sv
// Bench for ws_pe: a saturating and a wrapping instance share all inputs and
// are checked every cycle against a transaction-queue reference model.
module tb_ws_pe;

  localparam int DW = 16;
  localparam int WW = 16;
  localparam int AW = 40;
  localparam longint ACC_MAX = (longint'(1) <<< (AW - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (AW - 1));

  logic clk = 1'b0;
  logic rstn;
  logic stall_i, mode_i, w_load_i, w_swap_i, data_valid_i, psum_valid_i, ovf_clr_i;
  logic signed [WW-1:0] weight_i;
  logic signed [DW-1:0] data_i;
  logic signed [AW-1:0] psum_i;

  logic                 w_load_o, data_valid_o, psum_valid_o, ovf_o;
  logic signed [WW-1:0] weight_o;
  logic signed [DW-1:0] data_o;
  logic signed [AW-1:0] psum_o;
  logic                 w_load_o_w, data_valid_o_w, psum_valid_o_w, ovf_o_w;
  logic signed [WW-1:0] weight_o_w;
  logic signed [DW-1:0] data_o_w;
  logic signed [AW-1:0] psum_o_w;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ws_pe #(.DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .ACC_WIDTH(AW), .SATURATE(1'b1)) dut (
    .clk(clk), .rstn(rstn), .stall_i(stall_i), .mode_i(mode_i),
    .w_load_i(w_load_i), .weight_i(weight_i), .w_swap_i(w_swap_i),
    .w_load_o(w_load_o), .weight_o(weight_o),
    .data_valid_i(data_valid_i), .data_i(data_i),
    .data_valid_o(data_valid_o), .data_o(data_o),
    .psum_valid_i(psum_valid_i), .psum_i(psum_i),
    .psum_valid_o(psum_valid_o), .psum_o(psum_o),
    .ovf_clr_i(ovf_clr_i), .ovf_o(ovf_o)
  );

  ws_pe #(.DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .ACC_WIDTH(AW), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rstn(rstn), .stall_i(stall_i), .mode_i(mode_i),
    .w_load_i(w_load_i), .weight_i(weight_i), .w_swap_i(w_swap_i),
    .w_load_o(w_load_o_w), .weight_o(weight_o_w),
    .data_valid_i(data_valid_i), .data_i(data_i),
    .data_valid_o(data_valid_o_w), .data_o(data_o_w),
    .psum_valid_i(psum_valid_i), .psum_i(psum_i),
    .psum_valid_o(psum_valid_o_w), .psum_o(psum_o_w),
    .ovf_clr_i(ovf_clr_i), .ovf_o(ovf_o_w)
  );

  // Reference model: each accepted operand pair becomes a finished transaction
  // whose result leaves the PE two accepted cycles later.
  typedef struct {
    bit     vld;
    longint sat;
    longint wrap;
    bit     ovf;
  } txn_t;

  txn_t   q[$];
  txn_t   m_out;
  longint m_active, m_shadow, m_wo, m_do;
  bit     m_wlo, m_dvo, m_ovf;

  task automatic mdl_reset();
    txn_t z;
    z = '{vld: 1'b0, sat: 0, wrap: 0, ovf: 1'b0};
    q.delete();
    q.push_back(z);
    m_out = z;
    m_active = 0; m_shadow = 0; m_wo = 0; m_do = 0;
    m_wlo = 0; m_dvo = 0; m_ovf = 0;
  endtask

  task automatic mdl_step();
    txn_t   t, o;
    longint prod, add, sum;
    bit     n_ovf;
    o = '{vld: 1'b0, sat: 0, wrap: 0, ovf: 1'b0};
    n_ovf = ovf_clr_i ? 1'b0 : m_ovf;
    if (!stall_i) begin
      prod   = (data_valid_i && !mode_i) ? longint'(data_i) * m_active : 0;
      add    = psum_valid_i ? longint'(psum_i) : 0;
      sum    = add + prod;
      t.vld  = data_valid_i | psum_valid_i;
      t.ovf  = (sum > ACC_MAX) || (sum < ACC_MIN);
      t.sat  = (sum > ACC_MAX) ? ACC_MAX : (sum < ACC_MIN) ? ACC_MIN : sum;
      t.wrap = (sum <<< (64 - AW)) >>> (64 - AW);
      q.push_back(t);
      o      = q.pop_front();
      m_out  = o;
      m_do   = longint'(data_i);
      m_dvo  = data_valid_i;
      if (o.vld && o.ovf) n_ovf = 1'b1;
    end
    if (w_swap_i) m_active = m_shadow;
    if (w_load_i) m_shadow = longint'(weight_i);
    m_wo  = longint'(weight_i);
    m_wlo = w_load_i;
    m_ovf = n_ovf;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("data_o", longint'(data_o), m_do);
    chk("data_valid_o", longint'(data_valid_o), longint'(m_dvo));
    chk("psum_o_sat", longint'(psum_o), m_out.sat);
    chk("psum_valid_o", longint'(psum_valid_o), longint'(m_out.vld));
    chk("ovf_o_sat", longint'(ovf_o), longint'(m_ovf));
    chk("weight_o", longint'(weight_o), m_wo);
    chk("w_load_o", longint'(w_load_o), longint'(m_wlo));
    chk("psum_o_wrap", longint'(psum_o_w), m_out.wrap);
    chk("psum_valid_o_wrap", longint'(psum_valid_o_w), longint'(m_out.vld));
    chk("ovf_o_wrap", longint'(ovf_o_w), longint'(m_ovf));
    chk("data_o_wrap", longint'(data_o_w), m_do);
  endtask

  task automatic tick();
    mdl_step();
    @(posedge clk);
    #1;
    chk_model();
  endtask

  task automatic idle();
    stall_i = 0; mode_i = 0; w_load_i = 0; w_swap_i = 0; ovf_clr_i = 0;
    data_valid_i = 0; psum_valid_i = 0;
    weight_i = '0; data_i = '0; psum_i = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_psum_o"}, longint'(psum_o), 0);
    chk({tag, "_psum_valid_o"}, longint'(psum_valid_o), 0);
    chk({tag, "_data_o"}, longint'(data_o), 0);
    chk({tag, "_data_valid_o"}, longint'(data_valid_o), 0);
    chk({tag, "_weight_o"}, longint'(weight_o), 0);
    chk({tag, "_w_load_o"}, longint'(w_load_o), 0);
    chk({tag, "_ovf_o"}, longint'(ovf_o), 0);
    chk({tag, "_psum_o_wrap"}, longint'(psum_o_w), 0);
  endtask

  task automatic load_active(input logic signed [WW-1:0] w);
    idle(); w_load_i = 1; weight_i = w; tick();
    idle(); w_swap_i = 1; tick();
    idle();
  endtask

  task automatic mac(input logic signed [DW-1:0] d, input longint p);
    idle(); data_valid_i = 1; data_i = d; psum_valid_i = 1; psum_i = AW'(p); tick();
    idle();
  endtask

  typedef struct {
    logic signed [WW-1:0] w;
    logic signed [DW-1:0] d;
    longint               p;
    logic                 mode;
    longint               e_sat;
    longint               e_wrap;
    logic                 e_ovf;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{16'sd3,      16'sd5,      64'sd10,  1'b0, 64'sd25,  64'sd25,  1'b0};
    vecs[1] = '{-16'sd4,     16'sd7,      64'sd100, 1'b0, 64'sd72,  64'sd72,  1'b0};
    vecs[2] = '{16'sd4,      16'sd9,      64'sd123, 1'b1, 64'sd123, 64'sd123, 1'b0};
    vecs[3] = '{16'sd1,      16'sd1,      ACC_MAX,  1'b0, ACC_MAX,  ACC_MIN,  1'b1};
    vecs[4] = '{-16'sd1,     16'sd1,      ACC_MIN,  1'b0, ACC_MIN,  ACC_MAX,  1'b1};
    vecs[5] = '{16'sh8000,   16'sh8000,   64'sd0,   1'b0, 64'sd1073741824, 64'sd1073741824, 1'b0};
    vecs[6] = '{16'sd32767,  16'sh8000,   -64'sd5,  1'b0, -64'sd1073709061, -64'sd1073709061, 1'b0};

    idle();
    rstn = 0;
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    #4 rstn = 1;

    // Isolated MAC transactions from the vector table
    for (int i = 0; i < 7; i++) begin
      idle(); w_load_i = 1; weight_i = vecs[i].w; tick();
      idle(); w_swap_i = 1; ovf_clr_i = 1; tick();
      idle(); data_valid_i = 1; data_i = vecs[i].d; psum_valid_i = 1;
      psum_i = AW'(vecs[i].p); mode_i = vecs[i].mode; tick();
      chk("tbl_data_o", longint'(data_o), longint'(vecs[i].d));
      chk("tbl_data_valid_o", longint'(data_valid_o), 1);
      idle(); tick();
      chk("tbl_psum_sat", longint'(psum_o), vecs[i].e_sat);
      chk("tbl_psum_wrap", longint'(psum_o_w), vecs[i].e_wrap);
      chk("tbl_psum_valid", longint'(psum_valid_o), 1);
      chk("tbl_ovf", longint'(ovf_o), longint'(vecs[i].e_ovf));
    end
    idle(); ovf_clr_i = 1; tick();
    chk("ovf_cleared", longint'(ovf_o), 0);

    // Stall with a full pipeline: outputs hold, weight chain keeps moving
    load_active(16'sd3);
    for (int i = 1; i <= 4; i++) mac(DW'(i), longint'(i * 10));
    chk("pre_stall_psum", longint'(psum_o), 39);
    chk("pre_stall_data", longint'(data_o), 4);
    for (int k = 0; k < 3; k++) begin
      idle(); stall_i = 1; data_valid_i = 1; data_i = 16'sd99; psum_valid_i = 1;
      psum_i = 40'sd1000; weight_i = WW'(100 + k); tick();
      chk("stall_psum_hold", longint'(psum_o), 39);
      chk("stall_pvld_hold", longint'(psum_valid_o), 1);
      chk("stall_data_hold", longint'(data_o), 4);
      chk("stall_weight_o", longint'(weight_o), longint'(100 + k));
    end
    idle(); tick();
    chk("post_stall_psum", longint'(psum_o), 52);
    chk("post_stall_data_valid", longint'(data_valid_o), 0);
    idle(); tick();
    chk("post_stall_drain", longint'(psum_valid_o), 0);

    // Simultaneous load and swap: active takes old shadow
    idle(); w_load_i = 1; weight_i = 16'sd2; tick();
    idle(); w_load_i = 1; weight_i = 16'sd4; w_swap_i = 1; tick();
    mac(16'sd1, 0); tick();
    chk("ldswap_active_old_shadow", longint'(psum_o), 2);
    idle(); w_swap_i = 1; tick();
    mac(16'sd1, 0); tick();
    chk("ldswap_shadow_new", longint'(psum_o), 4);

    // Shadow load while streaming, then swap mid-stream
    load_active(16'sd3);
    for (int t = 1; t <= 6; t++) begin
      idle(); data_valid_i = 1; data_i = 16'sd2; psum_valid_i = 1; psum_i = '0;
      if (t == 2) begin w_load_i = 1; weight_i = 16'sd7; end
      if (t == 4) w_swap_i = 1;
      tick();
      if (t == 3) chk("stream_pre_load", longint'(psum_o), 6);
      if (t == 5) chk("stream_swap_cycle", longint'(psum_o), 6);
      if (t == 6) chk("stream_post_swap", longint'(psum_o), 14);
    end

    // Asynchronous reset mid-stream drops valids and both weights
    load_active(16'sd5);
    mac(16'sd3, 1); mac(16'sd4, 2);
    idle(); data_valid_i = 1; data_i = 16'sd6; psum_valid_i = 1; psum_i = 40'sd3;
    w_load_i = 1; weight_i = 16'sd9;
    rstn = 0;
    #1;
    chk_all_zero("midreset");
    mdl_reset();
    idle();
    #3 rstn = 1;
    mac(16'sd5, 77); tick();
    chk("reset_weight_lost", longint'(psum_o), 77);
    chk("reset_weight_lost_vld", longint'(psum_valid_o), 1);

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      longint r;
      idle();
      stall_i      = ($urandom_range(0, 4) == 0);
      mode_i       = ($urandom_range(0, 7) == 0);
      w_load_i     = ($urandom_range(0, 3) == 0);
      w_swap_i     = ($urandom_range(0, 5) == 0);
      ovf_clr_i    = ($urandom_range(0, 9) == 0);
      data_valid_i = ($urandom_range(0, 3) != 0);
      psum_valid_i = ($urandom_range(0, 3) != 0);
      weight_i     = WW'($urandom);
      data_i       = DW'($urandom);
      r            = longint'({$urandom, $urandom});
      if ($urandom_range(0, 3) == 0)
        r = ($urandom_range(0, 1) == 0) ? ACC_MAX - longint'($urandom_range(0, 1 << 20))
                                        : ACC_MIN + longint'($urandom_range(0, 1 << 20));
      psum_i = AW'(r);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ws_pe.md
# ws_pe

Parametrised weight-stationary processing element for the FFN systolic array, successor to the single-cycle MAC cell. Adds double-buffered weights (shadow load while computing, single-cycle swap), a daisy-chained weight load path, per-operand valid propagation, a stall input, a bypass mode, and saturating or wrapping partial-sum arithmetic with a sticky overflow flag. One instance sits at each grid point: data flows east, partial sums flow south, weights are chained down the column.

## Interface
- DATA_WIDTH, 16, signed activation width
- WEIGHT_WIDTH, 16, signed weight width
- ACC_WIDTH, 40, signed partial-sum width; must be >= DATA_WIDTH+WEIGHT_WIDTH
- SATURATE, 1, 1 = clamp partial sum on overflow; 0 = two's-complement wrap
---
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- stall_i  in  1  freeze data/psum pipeline
- mode_i  in  1  0 = MAC, 1 = bypass (product forced to 0)
- w_load_i  in  1  capture weight_i into shadow register
- weight_i  in  WEIGHT_WIDTH  weight from north neighbour / loader
- w_swap_i  in  1  copy shadow weight into active weight
- w_load_o  out  1  registered w_load_i to next PE
- weight_o  out  WEIGHT_WIDTH  registered weight_i to next PE
- data_valid_i  in  1  data_i valid
- data_i  in  DATA_WIDTH  activation from west
- data_valid_o  out  1  forwarded valid to east
- data_o  out  DATA_WIDTH  forwarded activation to east
- psum_valid_i  in  1  psum_i valid
- psum_i  in  ACC_WIDTH  partial sum from north
- psum_valid_o  out  1  partial-sum valid to south
- psum_o  out  ACC_WIDTH  partial sum to south
- ovf_clr_i  in  1  clear sticky overflow
- ovf_o  out  1  sticky overflow flag

## Operation
- Weights: w_load_i writes shadow <= weight_i. w_swap_i writes active <= shadow. Both same cycle: active takes the old shadow, shadow takes weight_i. Weight path ignores stall_i.
- Weight chain: weight_o/w_load_o are weight_i/w_load_i delayed one cycle, independent of stall.
- Stage 1 (accept when !stall_i): prod_r <= (data_valid_i && mode_i==0) ? data_i*active : 0; addend_r <= psum_valid_i ? psum_i : 0; v1_r <= data_valid_i | psum_valid_i. Active weight sampled here; a swap in cycle N affects data accepted in cycle N+1 onward.
- Stage 2 (when !stall_i): sum = addend_r + sign-extended prod_r, evaluated in ACC_WIDTH+1 bits. On overflow: SATURATE=1 -> clamp to max/min of ACC_WIDTH; SATURATE=0 -> keep low ACC_WIDTH bits. psum_o <= result, psum_valid_o <= v1_r.
- Overflow: ovf_o set when stage 2 updates with v1_r=1 and sum overflows (both SATURATE settings). ovf_clr_i clears; set wins when both occur in the same cycle.
- Forwarding: when !stall_i, data_o <= data_i and data_valid_o <= data_valid_i.
- Stall: all data/psum registers hold, including valids; output values stay stable.

## Timing
- Reset values: active, shadow, weight_o, w_load_o, data_o, data_valid_o, psum_o, psum_valid_o, ovf_o, and internal pipeline registers all 0.
- Latency: data_i -> data_o is 1 cycle; data_i/psum_i -> psum_o is 2 cycles; weight_i -> weight_o is 1 cycle.
- Full throughput: one operand pair per cycle when !stall_i.
- Reset mid-operation: in-flight valids are dropped, and both weights are lost and must be reloaded.
- Bypass: psum_o = psum_i delayed 2 cycles. data_o still forwards.

## Structure
- pe_pkg: pe_mode_e {PE_MAC, PE_BYPASS}, the sat_max/sat_min constants as functions of ACC_WIDTH, and the default width localparams.
- Sub-module sat_add: combinational (ACC_WIDTH+1)-bit add with clamp/wrap and overflow output. It is reused by the array's output drain.

## Test plan
- Load 3 (shadow), swap, send data 5 with psum 10 -> psum_o=25, psum_valid_o high 2 cycles after input; data_o=5 after 1 cycle.
- Shadow-load 7 while streaming data 2 with psum 0 and active weight 3, then swap -> outputs 6, 6, …, then 14 starting with the first post-swap datum.
- SATURATE=1, ACC_WIDTH=40, psum_i=2^39-1, data 1, weight 1 -> psum_o=2^39-1, ovf_o=1. With SATURATE=0 -> psum_o=-2^39.
- Assert stall_i for 3 cycles with the pipeline full -> psum_o/data_o and valids are held, and weight_o still advances. After release, output order is intact.
- mode_i=1, psum_i=123, data 9 -> psum_o=123. Simultaneous w_load 4 and w_swap with old shadow 2 -> active=2, shadow=4.
- Deassert rstn mid-stream -> all outputs 0 immediately. After release, a MAC with no reload yields psum_o=psum_i (weight 0).
